// File: rtl/cross_product_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cross_product_scheduler (+ signed_vector_cross_product)
//  Purpose  : Round-robin sharing of one signed 3-component cross-product unit
//             between two requesters, with a tagged valid/ready response.
//  Revision : 1.0 - initial release
// ============================================================================

module signed_vector_cross_product #(
    parameter int VEC_W = 57
) (
    input  logic [VEC_W-1:0] vec_a,
    input  logic [VEC_W-1:0] vec_b,
    output logic [VEC_W-1:0] vec_p
);
    localparam int c_CW = VEC_W / 3;

    logic signed [c_CW-1:0] w_ax, w_ay, w_az;
    logic signed [c_CW-1:0] w_bx, w_by, w_bz;
    logic signed [c_CW-1:0] w_px, w_py, w_pz;

    assign w_ax = vec_a[3*c_CW-1 -: c_CW];
    assign w_ay = vec_a[2*c_CW-1 -: c_CW];
    assign w_az = vec_a[c_CW-1 -: c_CW];
    assign w_bx = vec_b[3*c_CW-1 -: c_CW];
    assign w_by = vec_b[2*c_CW-1 -: c_CW];
    assign w_bz = vec_b[c_CW-1 -: c_CW];

    // Components wrap modulo 2^c_CW; only the low bits of each product are kept.
    assign w_px = w_ay * w_bz - w_az * w_by;
    assign w_py = w_az * w_bx - w_ax * w_bz;
    assign w_pz = w_ax * w_by - w_ay * w_bx;

    assign vec_p = {w_px, w_py, w_pz};
endmodule

module cross_product_scheduler #(
    parameter int VEC_W   = 57,
    parameter int TAG_W   = 4,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [VEC_W-1:0] req0_vec_a,
    input  logic [VEC_W-1:0] req0_vec_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [VEC_W-1:0] req1_vec_a,
    input  logic [VEC_W-1:0] req1_vec_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [VEC_W-1:0] rsp_vector,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_src,
    output logic             busy
);
    localparam int c_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VEC_W-1:0]   r_vec_a;
    logic [VEC_W-1:0]   r_vec_b;
    logic [VEC_W-1:0]   r_rsp_vector;
    logic [VEC_W-1:0]   w_product;
    logic [TAG_W-1:0]   r_tag;
    logic               r_src;
    logic               r_last_grant;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;
    logic               w_grant_src;

    signed_vector_cross_product #(
        .VEC_W (VEC_W)
    ) u_xprod (
        .vec_a (r_vec_a),
        .vec_b (r_vec_b),
        .vec_p (w_product)
    );

    // Under contention the requester that did not win last time is granted.
    assign w_grant_src = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_a      <= '0;
            r_vec_b      <= '0;
            r_rsp_vector <= '0;
            r_tag        <= '0;
            r_src        <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_vec_a      <= w_grant_src ? req1_vec_a : req0_vec_a;
            r_vec_b      <= w_grant_src ? req1_vec_b : req0_vec_b;
            r_tag        <= w_grant_src ? req1_tag : req0_tag;
            r_src        <= w_grant_src;
            r_last_grant <= w_grant_src;
            r_cnt        <= c_CNT_W'(LATENCY - 1);
        end else if (r_state == ST_COMPUTE) begin
            if (r_cnt == '0) begin
                r_rsp_vector <= w_product;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign req0_ready = w_accept & ~w_grant_src;
    assign req1_ready = w_accept &  w_grant_src;
    assign rsp_valid  = (r_state == ST_RESPOND);
    assign rsp_vector = r_rsp_vector;
    assign rsp_tag    = r_tag;
    assign rsp_src    = r_src;
    assign busy       = (r_state != ST_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_cross_product_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cross_product_scheduler
//  Purpose  : Self-checking bench; three schedulers with LATENCY 1, 4 and 15.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_cross_product_scheduler;
    localparam int VW = 57;
    localparam int TW = 4;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [ND-1:0] r0v, r1v, rr;
    logic [VW-1:0] r0a [ND];
    logic [VW-1:0] r0b [ND];
    logic [VW-1:0] r1a [ND];
    logic [VW-1:0] r1b [ND];
    logic [TW-1:0] r0t [ND];
    logic [TW-1:0] r1t [ND];
    wire  [ND-1:0] r0rdy, r1rdy, rv, rsrc, bsy;
    wire  [VW-1:0] rvec [ND];
    wire  [TW-1:0] rtag [ND];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        cross_product_scheduler #(
            .VEC_W   (VW),
            .TAG_W   (TW),
            .LATENCY ((g == 0) ? 1 : ((g == 1) ? 4 : 15))
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0_valid (r0v[g]),
            .req0_ready (r0rdy[g]),
            .req0_vec_a (r0a[g]),
            .req0_vec_b (r0b[g]),
            .req0_tag   (r0t[g]),
            .req1_valid (r1v[g]),
            .req1_ready (r1rdy[g]),
            .req1_vec_a (r1a[g]),
            .req1_vec_b (r1b[g]),
            .req1_tag   (r1t[g]),
            .rsp_valid  (rv[g]),
            .rsp_ready  (rr[g]),
            .rsp_vector (rvec[g]),
            .rsp_tag    (rtag[g]),
            .rsp_src    (rsrc[g]),
            .busy       (bsy[g])
        );
    end

    function automatic int lat(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 4 : 15);
    endfunction

    function automatic logic [VW-1:0] pk(input int x, input int y, input int z);
        return {19'(x), 19'(y), 19'(z)};
    endfunction

    function automatic logic [VW-1:0] xprod(input logic [VW-1:0] a, input logic [VW-1:0] b);
        longint ax, ay, az, bx, by, bz, x, y, z;
        ax = longint'($signed(a[56:38]));
        ay = longint'($signed(a[37:19]));
        az = longint'($signed(a[18:0]));
        bx = longint'($signed(b[56:38]));
        by = longint'($signed(b[37:19]));
        bz = longint'($signed(b[18:0]));
        x = ay * bz - az * by;
        y = az * bx - ax * bz;
        z = ax * by - ay * bx;
        return {19'(x), 19'(y), 19'(z)};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [18:0] c [3];
        for (int i = 0; i < 3; i++) begin
            case ($urandom_range(0, 4))
                0:       c[i] = 19'h40000;
                1:       c[i] = 19'h3FFFF;
                2:       c[i] = 19'($urandom_range(0, 15));
                default: c[i] = 19'($urandom);
            endcase
        end
        return {c[0], c[1], c[2]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Reference model: per scheduler, track whether an operation is outstanding,
    // how many cycles it has aged, and the result it must eventually return.
    bit            m_busy [ND] = '{0, 0, 0};
    bit            m_last [ND] = '{1, 1, 1};
    int            m_age  [ND] = '{0, 0, 0};
    logic [VW-1:0] m_vec  [ND];
    logic [TW-1:0] m_tag  [ND];
    bit            m_src  [ND];
    int            rsp_count [ND] = '{0, 0, 0};
    bit            g0, g1, expv;

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                check($sformatf("reset_ctrl%0d", d),
                      {r0rdy[d], r1rdy[d], rv[d], bsy[d], rsrc[d], rtag[d]}, 64'd0);
                check($sformatf("reset_vec%0d", d), rvec[d], 64'd0);
                m_busy[d] = 1'b0;
                m_last[d] = 1'b1;
            end else begin
                g0 = 1'b0;
                g1 = 1'b0;
                if (m_busy[d]) begin
                    m_age[d]++;
                end else begin
                    g0 = r0v[d] && (!r1v[d] || m_last[d]);
                    g1 = r1v[d] && (!r0v[d] || !m_last[d]);
                end
                expv = m_busy[d] && (m_age[d] >= lat(d) + 1);
                check($sformatf("mon_req0_ready%0d", d), r0rdy[d], g0);
                check($sformatf("mon_req1_ready%0d", d), r1rdy[d], g1);
                check($sformatf("mon_busy%0d", d), bsy[d], m_busy[d]);
                check($sformatf("mon_rsp_valid%0d", d), rv[d], expv);
                if (expv) begin
                    check($sformatf("mon_rsp_vector%0d", d), rvec[d], m_vec[d]);
                    check($sformatf("mon_rsp_tag%0d", d), rtag[d], m_tag[d]);
                    check($sformatf("mon_rsp_src%0d", d), rsrc[d], m_src[d]);
                    if (rr[d]) begin
                        m_busy[d] = 1'b0;
                        rsp_count[d]++;
                    end
                end
                if (g0 || g1) begin
                    m_busy[d] = 1'b1;
                    m_age[d]  = 0;
                    m_last[d] = g1;
                    m_src[d]  = g1;
                    m_vec[d]  = g1 ? xprod(r1a[d], r1b[d]) : xprod(r0a[d], r0b[d]);
                    m_tag[d]  = g1 ? r1t[d] : r0t[d];
                end
            end
        end
    end

    task automatic run_op(input int d, input bit src, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic [TW-1:0] tag, output logic [VW-1:0] vec, output logic [TW-1:0] otag,
                          output bit osrc, output int lat_seen, output int rdy_cycles);
        int acc_cyc, n;
        bit acc;
        acc = 1'b0; acc_cyc = 0; n = 0; lat_seen = -1; rdy_cycles = 0;
        vec = '0; otag = '0; osrc = 1'b0;
        @(posedge clk); #1;
        rr[d] = 1'b1;
        if (src) begin
            r1a[d] = a; r1b[d] = b; r1t[d] = tag; r1v[d] = 1'b1;
        end else begin
            r0a[d] = a; r0b[d] = b; r0t[d] = tag; r0v[d] = 1'b1;
        end
        while (lat_seen < 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (r0rdy[d] || r1rdy[d]) begin
                rdy_cycles++;
                if (!acc) begin
                    acc = 1'b1;
                    acc_cyc = cyc;
                end
                @(posedge clk); #1;
                r0v[d] = 1'b0;
                r1v[d] = 1'b0;
            end else if (acc && rv[d]) begin
                vec = rvec[d]; otag = rtag[d]; osrc = rsrc[d];
                lat_seen = cyc - acc_cyc;
            end
        end
        if (lat_seen < 0) begin
            timeout($sformatf("run_op%0d", d));
            r0v[d] = 1'b0;
            r1v[d] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        rr[d] = 1'b1;
        while ((bsy[d] || rv[d]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout($sformatf("wait_idle%0d", d));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit            src;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [TW-1:0] tag;
        logic [VW-1:0] exp;
    } vec_t;

    vec_t          tbl [5];
    logic [VW-1:0] v, hold;
    logic [TW-1:0] t;
    bit            s;
    int            l, rc, n, got;
    bit            srcs [4];
    logic [TW-1:0] tags [4];
    logic [ND-1:0] s0, s1;

    initial begin
        r0v = '0; r1v = '0; rr = '0;
        for (int d = 0; d < ND; d++) begin
            r0a[d] = '0; r0b[d] = '0; r1a[d] = '0; r1b[d] = '0; r0t[d] = '0; r1t[d] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rr = '1;

        // Expected products are hand-derived; the last entry wraps to x=1.
        tbl[0] = '{1'b0, pk(1, 0, 0), pk(0, 1, 0), 4'd3, pk(0, 0, 1)};
        tbl[1] = '{1'b1, pk(0, 1, 0), pk(1, 0, 0), 4'd9, pk(0, 0, -1)};
        tbl[2] = '{1'b0, pk(5, -7, 9), pk(5, -7, 9), 4'hE, pk(0, 0, 0)};
        tbl[3] = '{1'b1, pk(2, 3, 4), pk(5, 6, 7), 4'd0, pk(-3, 6, -3)};
        tbl[4] = '{1'b0, pk(0, 262143, 0), pk(0, 0, 262143), 4'hF, pk(1, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            run_op(0, tbl[i].src, tbl[i].a, tbl[i].b, tbl[i].tag, v, t, s, l, rc);
            check($sformatf("tbl%0d_vector", i), v, tbl[i].exp);
            check($sformatf("tbl%0d_tag", i), t, tbl[i].tag);
            check($sformatf("tbl%0d_src", i), s, tbl[i].src);
            check($sformatf("tbl%0d_latency", i), l, 2);
            check($sformatf("tbl%0d_ready_cycles", i), rc, 1);
        end

        // Contention straight after reset: requester 0 must win first.
        do_reset();
        r0a[0] = pk(1, 2, 3);  r0b[0] = pk(4, 5, 6); r0t[0] = 4'hA;
        r1a[0] = pk(-1, 0, 2); r1b[0] = pk(3, 3, 3); r1t[0] = 4'h5;
        r0v[0] = 1'b1; r1v[0] = 1'b1; rr[0] = 1'b1;
        got = 0; n = 0;
        while (got < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (rv[0] && rr[0]) begin
                srcs[got] = rsrc[0];
                tags[got] = rtag[0];
                got++;
            end
        end
        @(posedge clk); #1;
        r0v[0] = 1'b0; r1v[0] = 1'b0;
        check("contention_count", got, 4);
        for (int i = 0; i < got; i++) begin
            check($sformatf("contention_src%0d", i), srcs[i], i % 2);
            check($sformatf("contention_tag%0d", i), tags[i], (i % 2) ? 4'h5 : 4'hA);
        end
        wait_idle(0);

        // Back-pressure: response held for 10 cycles while requester 0 waits.
        @(posedge clk); #1;
        rr[0] = 1'b0;
        r1a[0] = pk(100, -200, 300); r1b[0] = pk(-7, 11, 13); r1t[0] = 4'h6; r1v[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!r1rdy[0] && n < 50);
        if (n >= 50) timeout("bp_accept");
        @(posedge clk); #1;
        r1v[0] = 1'b0;
        r0a[0] = pk(9, 9, 9); r0b[0] = pk(1, 2, 3); r0t[0] = 4'h2; r0v[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rv[0] && n < 50);
        if (n >= 50) timeout("bp_rsp_valid");
        hold = rvec[0];
        check("bp_vector", hold, xprod(pk(100, -200, 300), pk(-7, 11, 13)));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rv[0], 1'b1);
            check("bp_vector_stable", rvec[0], hold);
            check("bp_tag", rtag[0], 4'h6);
            check("bp_readies", {r0rdy[0], r1rdy[0]}, 2'b00);
            check("bp_busy", bsy[0], 1'b1);
        end
        @(posedge clk); #1;
        rr[0] = 1'b1;
        r0v[0] = 1'b0;
        @(negedge clk);
        check("bp_release_valid", rv[0], 1'b1);
        @(negedge clk);
        check("bp_done_valid", rv[0], 1'b0);
        check("bp_done_busy", bsy[0], 1'b0);

        // Latency sweep: accept-to-valid and back-to-back issue interval.
        for (int d = 0; d < ND; d++) begin
            int a1, a2, rf, k;
            a1 = -1; a2 = -1; rf = -1; k = 0;
            @(posedge clk); #1;
            rr[d] = 1'b1;
            r0a[d] = rand_vec(); r0b[d] = rand_vec(); r0t[d] = 4'(d); r0v[d] = 1'b1;
            while (a2 < 0 && k < 100) begin
                @(negedge clk);
                k++;
                if (r0rdy[d]) begin
                    if (a1 < 0) a1 = cyc;
                    else a2 = cyc;
                end
                if (rv[d] && a1 >= 0 && rf < 0) rf = cyc;
            end
            @(posedge clk); #1;
            r0v[d] = 1'b0;
            if (a2 < 0) timeout($sformatf("sweep%0d", d));
            check($sformatf("sweep%0d_latency", d), rf - a1, lat(d) + 1);
            check($sformatf("sweep%0d_interval", d), a2 - a1, lat(d) + 2);
            wait_idle(d);
        end

        // Reset two cycles into a LATENCY=4 operation drops it silently.
        @(posedge clk); #1;
        r0a[1] = pk(3, 1, 4); r0b[1] = pk(1, 5, 9); r0t[1] = 4'h7; r0v[1] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!r0rdy[1] && n < 50);
        if (n >= 50) timeout("rst_accept");
        @(posedge clk); #1;
        r0v[1] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("rst_pre_busy", bsy[1], 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async_ctrl", {bsy[1], rv[1], rsrc[1], rtag[1], r0rdy[1], r1rdy[1]}, 64'd0);
        check("rst_async_vec", rvec[1], 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rv[1]) n++;
        end
        check("rst_no_response", n, 0);
        run_op(1, 1'b1, pk(2, 3, 4), pk(5, 6, 7), 4'hC, v, t, s, l, rc);
        check("rst_next_vector", v, pk(-3, 6, -3));
        check("rst_next_src", s, 1'b1);
        check("rst_next_tag", t, 4'hC);
        check("rst_next_latency", l, lat(1) + 1);

        // Randomised traffic on all three schedulers, checked by the monitor.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            s0 = r0rdy;
            s1 = r1rdy;
            @(posedge clk); #1;
            for (int d = 0; d < ND; d++) begin
                if (s0[d]) r0v[d] = 1'b0;
                if (s1[d]) r1v[d] = 1'b0;
                if (!r0v[d] && $urandom_range(0, 2) == 0) begin
                    r0a[d] = rand_vec(); r0b[d] = rand_vec(); r0t[d] = 4'($urandom); r0v[d] = 1'b1;
                end
                if (!r1v[d] && $urandom_range(0, 2) == 0) begin
                    r1a[d] = rand_vec(); r1b[d] = rand_vec(); r1t[d] = 4'($urandom); r1v[d] = 1'b1;
                end
                rr[d] = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk); #1;
        r0v = '0; r1v = '0; rr = '1;
        for (int d = 0; d < ND; d++) begin
            wait_idle(d);
            check($sformatf("rand_responses%0d", d), rsp_count[d] > 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
